// File: rtl/prog_clk_div.sv
// prog_clk_div: NCH independent runtime-programmable clock-enable dividers with glitch-free reload.
// Optional feature macro CLK_DIV_SYNC_EN adds a 'sync' input that phase-aligns all enabled channels.
module prog_clk_div #(
    parameter int NCH     = 4,
    parameter int CW      = 27,
    parameter int CHW     = 2,
    parameter int DEF_DIV = 125000000
) (
    input  logic           clk_ref,
    input  logic           RST,
    input  logic [NCH-1:0] ch_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic           sync,
`endif
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_err,
    output logic [NCH-1:0] div_out,
    output logic [NCH-1:0] div_tick
);

    logic           cfg_ok;
    logic [NCH-1:0] wr_sel;

    // A write is only steered to a channel once both divisor and channel index are legal.
    always_comb begin
        cfg_ok = (cfg_div >= CW'(2)) && (32'(cfg_ch) < 32'(NCH));
        wr_sel = '0;
        for (int i = 0; i < NCH; i++)
            wr_sel[i] = cfg_wr && cfg_ok && (32'(cfg_ch) == 32'(i));
    end

    always_ff @(posedge clk_ref) begin
        if (RST) cfg_err <= 1'b0;
        else     cfg_err <= cfg_wr && !cfg_ok;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] d_q, s_q, p_q;
        logic [CW-1:0] d_n, s_n, p_n, h_n;
        logic          pend_q, pend_n, run_q, run_n;
        logic          restart, out_n, tick_n, out_q, tick_q;

        always_comb begin
            d_n    = d_q;
            s_n    = s_q;
            p_n    = p_q;
            pend_n = pend_q;
            run_n  = run_q;
`ifdef CLK_DIV_SYNC_EN
            restart = ch_en[g] && sync;
`else
            restart = 1'b0;
`endif
            if (!ch_en[g]) begin
                // Idle channel has no period in progress, so divisors take effect at once.
                run_n  = 1'b0;
                p_n    = '0;
                pend_n = 1'b0;
                if (wr_sel[g])   d_n = cfg_div;
                else if (pend_q) d_n = s_q;
            end else if (!run_q || restart || (p_q == d_q - CW'(1))) begin
                run_n = 1'b1;
                p_n   = '0;
                if (pend_q) begin
                    d_n    = s_q;
                    pend_n = 1'b0;
                end
                if (wr_sel[g]) begin
                    if (restart) begin
                        d_n    = cfg_div;
                        pend_n = 1'b0;
                    end else begin
                        s_n    = cfg_div;
                        pend_n = 1'b1;
                    end
                end
            end else begin
                p_n = p_q + CW'(1);
                if (wr_sel[g]) begin
                    s_n    = cfg_div;
                    pend_n = 1'b1;
                end
            end
            // Outputs are registered from next-state so they line up with the phase they describe.
            h_n    = CW'(({1'b0, d_n} + (CW+1)'(1)) >> 1);
            out_n  = ch_en[g] && (p_n < h_n);
            tick_n = ch_en[g] && (p_n == d_n - CW'(1));
        end

        always_ff @(posedge clk_ref) begin
            if (RST) begin
                d_q    <= CW'(DEF_DIV);
                s_q    <= '0;
                p_q    <= '0;
                pend_q <= 1'b0;
                run_q  <= 1'b0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                d_q    <= d_n;
                s_q    <= s_n;
                p_q    <= p_n;
                pend_q <= pend_n;
                run_q  <= run_n;
                out_q  <= out_n;
                tick_q <= tick_n;
            end
        end

        assign div_out[g]  = out_q;
        assign div_tick[g] = tick_q;
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: directed per-cycle vectors queued by stimulus, checked by a monitor.
module tb_prog_clk_div;
    localparam int NCH = 4, CW = 8, CHW = 3, DEF_DIV = 4;

    logic           clk_ref = 1'b0;
    logic           RST = 1'b1;
    logic           cfg_wr = 1'b0;
    logic           cfg_err;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] div_out, div_tick;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
`ifdef CLK_DIV_SYNC_EN
    logic           sync = 1'b0;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         stamp;
        string      name;
        logic [8:0] mask;
        logic [8:0] val;
    } exp_t;
    exp_t sbq[$];

    prog_clk_div #(.NCH(NCH), .CW(CW), .CHW(CHW), .DEF_DIV(DEF_DIV)) dut (
        .clk_ref (clk_ref),
        .RST     (RST),
        .ch_en   (ch_en),
`ifdef CLK_DIV_SYNC_EN
        .sync    (sync),
`endif
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_err (cfg_err),
        .div_out (div_out),
        .div_tick(div_tick)
    );

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    // Vector layout: {cfg_err, div_tick[3:0], div_out[3:0]}; expectation applies after the next edge.
    task automatic cyc1(input logic [3:0] en, input logic rst, input logic wr,
                        input logic [CHW-1:0] ch, input logic [CW-1:0] dv,
                        input string nm, input logic [8:0] mask, input logic [8:0] val
`ifdef CLK_DIV_SYNC_EN
                        , input logic s = 1'b0
`endif
                        );
        @(negedge clk_ref);
        RST = rst; ch_en = en; cfg_wr = wr; cfg_ch = ch; cfg_div = dv;
`ifdef CLK_DIV_SYNC_EN
        sync = s;
`endif
        if (mask != 9'h000) sbq.push_back('{cyc + 1, nm, mask, val});
    endtask

    task automatic seq(input string nm, input logic [3:0] en,
                       input logic [3:0] ma, input string oa, input string ta,
                       input logic [3:0] mb = 4'h0, input string ob = "", input string tb = "");
        logic [3:0] o, t;
        for (int k = 0; k < oa.len(); k++) begin
            o = '0; t = '0;
            if (oa[k] == "1") o = o | ma;
            if (ta[k] == "1") t = t | ma;
            if (mb != 4'h0) begin
                if (ob[k] == "1") o = o | mb;
                if (tb[k] == "1") t = t | mb;
            end
            cyc1(en, 1'b0, 1'b0, '0, '0, nm, {1'b1, ma | mb, ma | mb}, {1'b0, t, o});
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] act;
        forever begin
            @(negedge clk_ref);
            while (sbq.size() != 0 && sbq[0].stamp <= cyc) begin
                e   = sbq.pop_front();
                act = {cfg_err, div_tick, div_out};
                n_cmp++;
                if ((act & e.mask) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: got %b expected %b (mask %b)",
                             e.name, cyc, act & e.mask, e.val, e.mask);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        n_bad++;
        $display("FAIL watchdog: stimulus did not complete, %0d expectations left", sbq.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stimulus
        cyc1(4'h0, 1'b1, 1'b0, '0, '0, "reset",      9'h1FF, 9'h000);
        cyc1(4'h0, 1'b1, 1'b0, '0, '0, "reset_hold", 9'h1FF, 9'h000);

        // Default divisor 4 on all channels straight out of reset.
        seq("def_div", 4'hF, 4'hF, "11001100", "00010001");

        // Odd divisor loaded while idle, visible from first enabled cycle.
        cyc1(4'b1101, 1'b0, 1'b0, '0, '0, "ch1_off", 9'h022, 9'h000);
        cyc1(4'b1101, 1'b0, 1'b1, 3'd1, 8'd5, "ch1_wr_idle", 9'h122, 9'h000);
        seq("odd_div", 4'hF, 4'b0010, "1110011100", "0000100001");

        // Reload mid-period: old period of 4 completes, then 8 with 4 high.
        cyc1(4'b1110, 1'b0, 1'b0, '0, '0, "ch0_off", 9'h011, 9'h000);
        cyc1(4'hF, 1'b0, 1'b0, '0, '0, "reload_p0", 9'h111, 9'h001);
        cyc1(4'hF, 1'b0, 1'b1, 3'd0, 8'd8, "reload_p1", 9'h111, 9'h001);
        seq("reload", 4'hF, 4'b0001, "00111100001", "01000000010");

        // Rejected writes pulse cfg_err one cycle later and leave divisors alone.
        cyc1(4'hF, 1'b0, 1'b1, 3'd0, 8'd1, "rej_div1", 9'h100, 9'h100);
        cyc1(4'hF, 1'b0, 1'b1, 3'd5, 8'd6, "rej_ch5",  9'h100, 9'h100);
        cyc1(4'hF, 1'b0, 1'b0, '0, '0, "err_clear", 9'h100, 9'h000);
        cyc1(4'b1100, 1'b0, 1'b0, '0, '0, "ch01_off", 9'h033, 9'h000);
        seq("rej_keep0", 4'b1101, 4'b0001, "111100001", "000000010");
        seq("rej_keep1", 4'hF, 4'b0010, "111001", "000010");

        // Reset mid-period drops a pending write and restores the default divisor.
        cyc1(4'hF, 1'b0, 1'b1, 3'd2, 8'd6, "wr_pend", 9'h100, 9'h000);
        cyc1(4'hF, 1'b1, 1'b0, '0, '0, "rst_mid", 9'h1FF, 9'h000);
        seq("rst_def", 4'hF, 4'hF, "110011001", "000100010");

        // Disable with a simultaneous write: output drops next cycle, divisor loads directly.
        cyc1(4'b1011, 1'b0, 1'b1, 3'd2, 8'd3, "ch2_off_wr", 9'h144, 9'h000);
        seq("ch2_d3", 4'hF, 4'b0100, "110110", "001001");

`ifdef CLK_DIV_SYNC_EN
        // Skew ch1 against ch0, then sync with a write to ch1 landing on the sync edge.
        cyc1(4'b1101, 1'b0, 1'b0, '0, '0, "pre_sync", 9'h000, 9'h000);
        cyc1(4'hF, 1'b0, 1'b0, '0, '0, "pre_sync", 9'h000, 9'h000);
        cyc1(4'hF, 1'b0, 1'b0, '0, '0, "pre_sync", 9'h000, 9'h000);
        cyc1(4'hF, 1'b0, 1'b1, 3'd1, 8'd6, "sync_edge", 9'h033, 9'h003, 1'b1);
        seq("sync_run", 4'hF, 4'b0001, "100110011001", "001000100010",
            4'b0010, "110001110001", "000010000010");
`endif

        repeat (3) @(negedge clk_ref);
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations never checked, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Multi-channel, runtime-programmable clock divider; the parametrised successor of the fixed per-output divide chains. One reference clock feeds NCH independent divider channels. Each channel produces a near-50% square output and a one-cycle end-of-period tick. Divide ratios are loaded through a simple write port and applied glitch-free at period boundaries. The block sits directly after the clock generator and drives the slow display/LED/timebase logic with enables rather than derived clocks.

## Interface
- NCH, 4: number of divider channels (1..16).
- CW, 27: divisor/counter width; covers 125 MHz to 1 Hz.
- CHW, 2: channel-select width; must satisfy 2^CHW >= NCH, minimum 1.
- DEF_DIV, 125000000: divisor loaded into every channel on reset; must be >= 2.

- clk_ref  in  1  reference clock; only clock in the block.
- RST  in  1  synchronous, active-high reset.
- ch_en  in  NCH  per-channel run enable.
- cfg_wr  in  1  one-cycle write strobe.
- cfg_ch  in  CHW  target channel for the write.
- cfg_div  in  CW  new divisor D (full period, in clk_ref cycles).
- cfg_err  out  1  one-cycle pulse flagging a rejected write.
- div_out  out  NCH  square outputs, bit i = channel i.
- div_tick  out  NCH  end-of-period pulses, bit i = channel i.

## Operation
- Each channel has:
  - active divisor D.
  - shadow divisor S with a pending flag.
  - phase counter p in 0..D-1.
- High time: H = (D+1)>>1.
  - div_out = 1 while p < H, 0 otherwise.
  - Odd D gives one extra high cycle, e.g. D=3 gives 2 high, 1 low.
- div_tick = 1 exactly while p = D-1.
- Running channel: p increments each edge; wraps from D-1 to 0.
- Write, accepted when cfg_div >= 2 and cfg_ch < NCH:
  - S <= cfg_div, pending set; a second write before apply overwrites S (last wins).
  - Pending S becomes D at the first wrap edge strictly after the capture edge.
  - The period in progress always completes with the old D, so there are no runt pulses.
- Disabled channel (ch_en[i]=0):
  - Next edge: p idle, div_out=0, div_tick=0.
  - An accepted write to a disabled channel loads D directly; no pending state.
- Re-enable: the first edge with ch_en[i]=1 sets p=0; div_out is high from that cycle.
- Rejected write (cfg_div < 2, or cfg_ch >= NCH):
  - No state changes.
  - cfg_err = 1 for the cycle after the strobe.
- Reset:
  - D = DEF_DIV, pending cleared, channels idle.
  - div_out = 0, div_tick = 0, cfg_err = 0.
  - The first edge with RST low and ch_en[i]=1 sets p=0.
- Reset mid-period aborts immediately and discards pending writes.
- Channels are fully independent; no shared arithmetic between them.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Enable, write and sync effects are visible one edge after the input is sampled.
- Enable-to-first-output latency: 1 cycle.
- Period of div_out and div_tick: exactly D cycles in steady state.
- Write on the same edge as a wrap: captured, applied at the following wrap (one full old period later).
- Write on the same edge as ch_en falling: D loaded directly.

## Configuration
- Feature macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds input port sync (1 bit), placed after ch_en.
  - sync=1 forces every enabled channel to p=0 at the next edge, applying any pending S at that edge.
  - A write captured on the sync edge applies at that same edge.
  - Used to phase-align all outputs.
- Undefined: the sync port and its logic are absent; channels free-run from their own enable edges.

## Test plan
- Default divisor: NCH=4, DEF_DIV=4, all enabled after reset -> each div_out gives 2 high / 2 low; div_tick high one cycle in four, coincident with the 4th cycle.
- Odd divisor: write ch1 D=5 while ch1 disabled, then enable -> div_out[1] gives 3 high / 2 low, period 5, from the first enabled cycle.
- Glitch-free reload: ch0 running D=4; write D=8 at phase 1 -> the current period finishes at 4, the next period is 8 with 4 high.
- Rejected writes: write D=1 to ch0, then D=6 to cfg_ch=5 with NCH=4 -> cfg_err pulses one cycle after each; divisors unchanged.
- Reset and enable: RST mid-period with a write pending -> outputs 0 the next cycle, D back to DEF_DIV; deasserting ch_en[2] drops div_out[2] to 0 in 1 cycle.
- Sync (CLK_DIV_SYNC_EN defined): ch0 D=4, ch1 D=6 at arbitrary phases, pulse sync -> both outputs rise on the same cycle; div_tick coincides every 12 cycles.
